jet_build_sched: RTL and testbench

Sequencing and collection controller for the L2 jet-finding stage. It resets and starts NLANE parallel per-eta jet builders once per event, and tracks their `done` flags with a timeout. It merges their jet streams through per-lane FIFOs and a round-robin arbiter into a single ready/valid output. It sits between the event control logic and the downstream jet sorter.

---
 rtl/jet_sched_pkg.sv | 30 +++
 rtl/jet_lane_fifo.sv | 48 ++++
 rtl/jet_build_sched.sv | 194 +++++++++++++++++++
 tb/tb_jet_build_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jet_sched_pkg.sv
// Shared definitions for the L2 jet build scheduler.
//   JET_W / field offsets : layout of a jet word {nt, nx, phi, pt}
//   sched_state_t         : event sequencing states
//   lane_w()              : width of a lane index (at least one bit)
package jet_sched_pkg;

    localparam int JET_W      = 23;
    localparam int JET_PT_LSB  = 0;
    localparam int JET_PT_W    = 9;
    localparam int JET_PHI_LSB = 9;
    localparam int JET_PHI_W   = 5;
    localparam int JET_NX_LSB  = 14;
    localparam int JET_NX_W    = 4;
    localparam int JET_NT_LSB  = 18;
    localparam int JET_NT_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_GO,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } sched_state_t;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jet_lane_fifo.sv
// Per-lane jet FIFO. Combinational read of the head word, registered write.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous flush (start of a new event)
//   push, din  : write strobe and word; caller never pushes a full FIFO
//                unless it pops in the same cycle
//   pop        : advance head; caller never pops an empty FIFO
//   full, empty, dout : status and head word
// DEPTH must be a power of two, at least 2 (pointers carry one wrap bit).
module jet_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jet_build_sched.sv
// Event sequencer and jet collector for the L2 jet-finding stage.
// Resets/starts NLANE builders once per event, tracks their done flags
// with a timeout, and merges the per-lane jet streams through FIFOs and a
// round-robin arbiter into one registered ready/valid output.
//   clk, reset          : clock, synchronous active-high reset
//   ev_start            : new-event request (honoured only in IDLE)
//   ev_busy, ev_done    : event in progress / one-cycle completion pulse
//   ev_timeout, ovf     : sticky status, cleared at the next event's CLR
//   bld_reset, bld_start: builder controls (broadcast)
//   bld_done            : per-lane builder done levels
//   jet_in, jet_in_valid: per-lane jet words (lane k at [23k+22:23k])
//   jet_out, jet_lane, jet_out_valid, jet_out_ready : merged output
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for ev_start
// ST_CLR   | builders held in reset; done bits, timer, status, FIFOs cleared
// ST_GO    | builder start pulse
// ST_RUN   | collecting done flags, counting toward the timeout
// ST_DRAIN | waiting for FIFOs and the output register to empty
// ST_FIN   | ev_done pulse
module jet_build_sched
    import jet_sched_pkg::*;
#(
    parameter int NLANE   = 6,
    parameter int FDEPTH  = 4,
    parameter int TIMEOUT = 64,
    localparam int LW     = lane_w(NLANE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ev_start,
    output logic                   ev_busy,
    output logic                   ev_done,
    output logic                   ev_timeout,
    output logic                   ovf,
    output logic                   bld_reset,
    output logic                   bld_start,
    input  logic [NLANE-1:0]       bld_done,
    input  logic [NLANE*JET_W-1:0] jet_in,
    input  logic [NLANE-1:0]       jet_in_valid,
    output logic [JET_W-1:0]       jet_out,
    output logic [LW-1:0]          jet_lane,
    output logic                   jet_out_valid,
    input  logic                   jet_out_ready
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    sched_state_t state;
    sched_state_t state_nx;
    logic         timed_out;

    logic [NLANE-1:0] seen;
    logic [TW-1:0]    to_cnt;

    logic             capture;
    logic [NLANE-1:0] fifo_push;
    logic [NLANE-1:0] fifo_pop;
    logic [NLANE-1:0] fifo_full;
    logic [NLANE-1:0] fifo_empty;
    logic [NLANE-1:0] drop;
    logic [JET_W-1:0] fifo_dout [NLANE];

    logic [LW-1:0]    last_grant;
    logic [LW-1:0]    grant;
    logic [LW-1:0]    cand;
    logic             grant_vld;
    logic             pop_any;
    int               cand_i;

    // ---------------- FSM ----------------
    always_comb begin
        state_nx  = state;
        timed_out = 1'b0;
        case (state)
            ST_IDLE:  if (ev_start) state_nx = ST_CLR;
            ST_CLR:   state_nx = ST_GO;
            ST_GO:    state_nx = ST_RUN;
            ST_RUN: begin
                // A done seen in this very cycle counts, so the last lane's
                // done moves us to DRAIN on the next cycle.
                if (&(seen | bld_done)) begin
                    state_nx = ST_DRAIN;
                end else if (to_cnt == TO_LAST) begin
                    state_nx  = ST_DRAIN;
                    timed_out = 1'b1;
                end
            end
            ST_DRAIN: if (&fifo_empty && !jet_out_valid) state_nx = ST_FIN;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            seen       <= '0;
            to_cnt     <= '0;
            ev_busy    <= 1'b0;
            ev_done    <= 1'b0;
            ev_timeout <= 1'b0;
            ovf        <= 1'b0;
            bld_reset  <= 1'b1;
            bld_start  <= 1'b0;
        end else begin
            state     <= state_nx;
            ev_busy   <= (state_nx != ST_IDLE);
            ev_done   <= (state_nx == ST_FIN);
            bld_reset <= (state_nx == ST_CLR);
            bld_start <= (state_nx == ST_GO);

            if (state == ST_CLR) begin
                seen   <= '0;
                to_cnt <= '0;
            end else if (state == ST_RUN) begin
                seen   <= seen | bld_done;
                to_cnt <= to_cnt + 1'b1;
            end

            // Status is cleared on entry so it already reads 0 during CLR.
            if (state_nx == ST_CLR) begin
                ev_timeout <= 1'b0;
                ovf        <= 1'b0;
            end else begin
                if (timed_out) ev_timeout <= 1'b1;
                if (|drop)     ovf        <= 1'b1;
            end
        end
    end

    // ---------------- Lane FIFOs ----------------
    assign capture = (state == ST_GO) || (state == ST_RUN) || (state == ST_DRAIN);

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        // A full FIFO still accepts a word when its head is popped this cycle.
        assign fifo_push[k] = capture && jet_in_valid[k] && (!fifo_full[k] || fifo_pop[k]);
        assign drop[k]      = capture && jet_in_valid[k] && fifo_full[k] && !fifo_pop[k];
        assign fifo_pop[k]  = pop_any && (grant == LW'(k));

        jet_lane_fifo #(
            .DEPTH (FDEPTH),
            .WIDTH (JET_W)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .clr   (state == ST_CLR),
            .push  (fifo_push[k]),
            .pop   (fifo_pop[k]),
            .din   (jet_in[JET_W*k +: JET_W]),
            .full  (fifo_full[k]),
            .empty (fifo_empty[k]),
            .dout  (fifo_dout[k])
        );
    end

    // ---------------- Round-robin arbiter ----------------
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        cand_i    = 0;
        for (int i = 0; i < NLANE; i++) begin
            cand_i = (int'(last_grant) + 1 + i) % NLANE;
            cand   = LW'(cand_i);
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    assign pop_any = grant_vld && (!jet_out_valid || jet_out_ready);

    // ---------------- Output register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            jet_out       <= '0;
            jet_lane      <= '0;
            jet_out_valid <= 1'b0;
            last_grant    <= LW'(NLANE - 1);
        end else if (pop_any) begin
            jet_out       <= fifo_dout[grant];
            jet_lane      <= grant;
            jet_out_valid <= 1'b1;
            last_grant    <= grant;
        end else if (jet_out_ready) begin
            jet_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jet_build_sched.sv
// Directed bench for jet_build_sched with hand-computed expectations.
module tb_jet_build_sched;
    import jet_sched_pkg::*;

    localparam int NLANE   = 6;
    localparam int FDEPTH  = 4;
    localparam int TIMEOUT = 64;
    localparam int LW      = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ev_start;
    logic                   ev_busy;
    logic                   ev_done;
    logic                   ev_timeout;
    logic                   ovf;
    logic                   bld_reset;
    logic                   bld_start;
    logic [NLANE-1:0]       bld_done;
    logic [NLANE*JET_W-1:0] jet_in;
    logic [NLANE-1:0]       jet_in_valid;
    logic [JET_W-1:0]       jet_out;
    logic [LW-1:0]          jet_lane;
    logic                   jet_out_valid;
    logic                   jet_out_ready;

    jet_build_sched #(
        .NLANE   (NLANE),
        .FDEPTH  (FDEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ev_start      (ev_start),
        .ev_busy       (ev_busy),
        .ev_done       (ev_done),
        .ev_timeout    (ev_timeout),
        .ovf           (ovf),
        .bld_reset     (bld_reset),
        .bld_start     (bld_start),
        .bld_done      (bld_done),
        .jet_in        (jet_in),
        .jet_in_valid  (jet_in_valid),
        .jet_out       (jet_out),
        .jet_lane      (jet_lane),
        .jet_out_valid (jet_out_valid),
        .jet_out_ready (jet_out_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [JET_W-1:0] got_w [$];
    int               got_l [$];
    int               got_c [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [JET_W-1:0] mkjet(input int lane, input int seq);
        return {5'(lane + 1), 4'(seq), 5'(lane * 3 + seq), 9'(lane * 40 + seq * 3 + 1)};
    endfunction

    task automatic set_jet(input int lane, input logic [JET_W-1:0] w);
        jet_in[JET_W*lane +: JET_W] = w;
    endtask

    task automatic clear_q();
        got_w.delete();
        got_l.delete();
        got_c.delete();
    endtask

    // Called in an IDLE cycle; returns in the first RUN cycle.
    task automatic start_event(input string tag);
        ev_start = 1'b1;
        tick();
        ev_start = 1'b0;
        check({tag, "_bld_reset_t1"}, {31'd0, bld_reset}, 1);
        tick();
        check({tag, "_bld_start_t2"}, {bld_reset, bld_start}, 2'b01);
        tick();
        check({tag, "_busy_run"}, {bld_start, ev_busy}, 2'b01);
    endtask

    // Records output handshakes until ev_done, bounded by max cycles.
    task automatic drain_event(input string tag, input int max);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (jet_out_valid && jet_out_ready) begin
                got_w.push_back(jet_out);
                got_l.push_back(int'(jet_lane));
                got_c.push_back(cyc);
            end
            if (ev_done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_ev_done_seen"}, {31'd0, found}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n4;

        reset         = 1'b1;
        ev_start      = 1'b0;
        bld_done      = '0;
        jet_in        = '0;
        jet_in_valid  = '0;
        jet_out_ready = 1'b0;
        tick(2);
        check("rst_bld_reset", {31'd0, bld_reset}, 1);
        check("rst_outs", {ev_busy, ev_done, ev_timeout, ovf, bld_start, jet_out_valid}, 6'b0);
        reset = 1'b0;
        tick();
        check("post_rst_bld_reset", {31'd0, bld_reset}, 0);

        // ---- Basic event: done at RUN+30, ev_done at RUN+32 ----
        start_event("basic");
        ev_start = 1'b1;              // ignored outside IDLE
        tick();
        ev_start = 1'b0;
        tick(29);                     // RUN+30
        bld_done = '1;
        tick();                       // RUN+31
        check("basic_no_done_r31", {31'd0, ev_done}, 0);
        tick();                       // RUN+32
        check("basic_done_r32", {31'd0, ev_done}, 1);
        check("basic_status", {ev_timeout, ovf}, 2'b00);
        bld_done = '0;
        tick();
        check("basic_done_1cyc", {ev_done, ev_busy}, 2'b00);

        // ---- Simultaneous jets on lanes 0, 2, 5 ----
        start_event("simul");
        jet_out_ready = 1'b1;
        clear_q();
        set_jet(0, mkjet(0, 1));
        set_jet(2, mkjet(2, 1));
        set_jet(5, mkjet(5, 1));
        jet_in_valid = 6'b100101;
        tick();
        jet_in_valid = '0;
        bld_done     = '1;
        drain_event("simul", 20);
        bld_done = '0;
        tick();
        check("simul_count", got_l.size(), 3);
        if (got_l.size() == 3) begin
            check("simul_lane0", got_l[0], 0);
            check("simul_lane1", got_l[1], 2);
            check("simul_lane2", got_l[2], 5);
            check("simul_word0", got_w[0], mkjet(0, 1));
            check("simul_word1", got_w[1], mkjet(2, 1));
            check("simul_word2", got_w[2], mkjet(5, 1));
            check("simul_consec", {got_c[1] - got_c[0], got_c[2] - got_c[1]}, {32'd1, 32'd1});
        end

        // ---- Backpressure and round-robin between lanes 1 and 3 ----
        start_event("bp");
        jet_out_ready = 1'b0;
        clear_q();
        for (int s = 0; s < 4; s++) begin
            set_jet(1, mkjet(1, s));
            set_jet(3, mkjet(3, s));
            jet_in_valid = 6'b001010;
            tick();
        end
        jet_in_valid = '0;
        bad = 0;
        for (int s = 0; s < 6; s++) begin
            if (!jet_out_valid || jet_out !== mkjet(1, 0) || jet_lane !== 3'd1) bad++;
            tick();
        end
        check("bp_stall_stable", bad, 0);
        jet_out_ready = 1'b1;
        bld_done      = '1;
        drain_event("bp", 30);
        bld_done = '0;
        check("bp_ovf", {31'd0, ovf}, 0);
        tick();
        check("bp_count", got_l.size(), 8);
        for (int i = 0; i < got_l.size() && i < 8; i++) begin
            check($sformatf("bp_lane%0d", i), got_l[i], (i % 2 == 0) ? 1 : 3);
            check($sformatf("bp_word%0d", i), got_w[i], mkjet((i % 2 == 0) ? 1 : 3, i / 2));
        end

        // ---- Overflow on lane 4 ----
        // A lane-0 jet occupies the output register first, so only the FIFO
        // depth bounds what lane 4 can hold during the stall.
        start_event("ovf");
        jet_out_ready = 1'b0;
        clear_q();
        set_jet(0, mkjet(0, 9));
        jet_in_valid = 6'b000001;
        tick();
        jet_in_valid = '0;
        tick();
        for (int s = 0; s < 6; s++) begin
            set_jet(4, mkjet(4, s));
            jet_in_valid = 6'b010000;
            tick();
        end
        jet_in_valid = '0;
        tick();
        check("ovf_set", {31'd0, ovf}, 1);
        jet_out_ready = 1'b1;
        bld_done      = '1;
        drain_event("ovf", 30);
        bld_done = '0;
        check("ovf_sticky", {31'd0, ovf}, 1);
        tick();
        check("ovf_first_lane0", (got_l.size() > 0) ? got_w[0] : 23'h0, mkjet(0, 9));
        n4 = 0;
        bad = 0;
        for (int i = 0; i < got_l.size(); i++) begin
            if (got_l[i] == 4) begin
                if (got_w[i] !== mkjet(4, n4)) bad++;
                n4++;
            end
        end
        check("ovf_lane4_count", n4, 4);
        check("ovf_lane4_words", bad, 0);

        // ---- Timeout: lane 2 never reports done ----
        start_event("to");            // RUN cycle r
        check("to_ovf_cleared", {31'd0, ovf}, 0);
        bld_done = 6'b111011;
        tick(63);                     // r+63
        check("to_not_yet", {ev_timeout, ev_busy}, 2'b01);
        tick();                       // r+64
        check("to_set_r64", {ev_timeout, ev_done}, 2'b10);
        tick();                       // r+65
        check("to_ev_done", {31'd0, ev_done}, 1);
        bld_done = '0;
        tick();
        check("to_held_idle", {ev_timeout, ev_busy}, 2'b10);
        start_event("rstmid");
        check("to_cleared_next", {31'd0, ev_timeout}, 0);

        // ---- Reset mid-RUN with three jets buffered ----
        jet_out_ready = 1'b0;
        set_jet(0, mkjet(0, 5));
        set_jet(1, mkjet(1, 5));
        set_jet(2, mkjet(2, 5));
        jet_in_valid = 6'b000111;
        tick();
        jet_in_valid = '0;
        tick(2);
        check("rstmid_pending", {31'd0, jet_out_valid}, 1);
        reset = 1'b1;
        tick();
        check("rstmid_idle", {jet_out_valid, ev_busy, bld_reset}, 3'b001);
        reset         = 1'b0;
        jet_out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ev_done || jet_out_valid) bad++;
            tick();
        end
        check("rstmid_quiet", bad, 0);

        // Following event runs normally; arbiter priority restarts at lane 0.
        start_event("after");
        clear_q();
        set_jet(1, mkjet(1, 7));
        set_jet(4, mkjet(4, 7));
        jet_in_valid = 6'b010010;
        bld_done     = '1;
        tick();
        jet_in_valid = '0;
        drain_event("after", 20);
        bld_done = '0;
        tick();
        check("after_count", got_l.size(), 2);
        if (got_l.size() == 2) begin
            check("after_lane_order", {got_l[0], got_l[1]}, {32'd1, 32'd4});
            check("after_words", {9'd0, got_w[0]}, {9'd0, mkjet(1, 7)});
            check("after_word1", {9'd0, got_w[1]}, {9'd0, mkjet(4, 7)});
        end
        check("after_status", {ev_timeout, ovf, ev_busy}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
